// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: raster counters, per-pixel buffer requests, and a
// three-stage alignment pipeline that places the returned RGB444 pixel on
// the same clock as its hsync/vsync/data-enable.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 12
) (
    input  logic             clk_v,
    input  logic             reset_v,
    input  logic             enable_i,
    input  logic [11:0]      data_i,
    output logic             data_req_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [11:0]      rgb_o,
    output logic             frame_start_o,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // The ping-pong buffer swaps halves every 128 pixels, so a frame must
    // consume a whole number of halves or the halves drift frame to frame.
    if ((H_ACTIVE * V_ACTIVE) % 128 != 0) begin : g_frame_size_chk
        $error("vga_timing_ctrl: H_ACTIVE*V_ACTIVE must be a multiple of 128");
    end
    if ((H_TOTAL >= (1 << CNT_W)) || (V_TOTAL >= (1 << CNT_W))) begin : g_cnt_w_chk
        $error("vga_timing_ctrl: CNT_W too narrow for the raster totals");
    end

    // Pin level for a sync strobe given its asserted polarity.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic active_p0, hs_p0, vs_p0, sof_p0;

    logic req_p1_q, de_p1_q, sof_p1_q, hs_p1_q, vs_p1_q;
    logic de_p2_q, sof_p2_q, hs_p2_q, vs_p2_q;

    logic [11:0] rgb_q;
    logic        de_q, hsync_q, vsync_q, fs_q;

    // Stage 0: next raster position; disabled means parked at the frame origin
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
        end else begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end
    end

    // Counter registers
    always_ff @(posedge clk_v) begin
        if (reset_v) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decode of the current raster position
    always_comb begin
        active_p0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_p0     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_p0     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        sof_p0    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Stage 1: issue the buffer request and carry the decoded strobes
    always_ff @(posedge clk_v) begin
        if (reset_v) begin
            req_p1_q <= 1'b0;
            de_p1_q  <= 1'b0;
            sof_p1_q <= 1'b0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
        end else begin
            req_p1_q <= enable_i & active_p0;
            de_p1_q  <= enable_i & active_p0;
            sof_p1_q <= enable_i & sof_p0;
            hs_p1_q  <= hs_p0;
            vs_p1_q  <= vs_p0;
        end
    end

    // Stage 2: wait out the buffer's registered read
    always_ff @(posedge clk_v) begin
        if (reset_v) begin
            de_p2_q  <= 1'b0;
            sof_p2_q <= 1'b0;
            hs_p2_q  <= 1'b0;
            vs_p2_q  <= 1'b0;
        end else begin
            de_p2_q  <= de_p1_q;
            sof_p2_q <= sof_p1_q;
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
        end
    end

    // Stage 3: registered pins; pixel data is blanked outside active video
    always_ff @(posedge clk_v) begin
        if (reset_v) begin
            rgb_q   <= 12'h000;
            de_q    <= 1'b0;
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= de_p2_q ? data_i : 12'h000;
            de_q    <= de_p2_q;
            hsync_q <= sync_level(hs_p2_q, HS_ON);
            vsync_q <= sync_level(vs_p2_q, VS_ON);
            fs_q    <= sof_p2_q & de_p2_q;
        end
    end

    assign data_req_o    = req_p1_q;
    assign de_o          = de_q;
    assign rgb_o         = rgb_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = fs_q;
    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-size instance for line timing and
// enable handling, a small active-low instance with an echo buffer model
// feeding a scoreboard, and a small active-high instance fed 12'hFFF.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en_def, en_sml, def_mon;
    logic [11:0] d_def, d_sml;
    logic [11:0] d_pos = 12'hFFF;

    logic        req_def, hs_def, vs_def, de_def, fs_def;
    logic [11:0] rgb_def, h_def, v_def;
    logic        req_sml, hs_sml, vs_sml, de_sml, fs_sml;
    logic [11:0] rgb_sml, h_sml, v_sml;
    logic        req_pos, hs_pos, vs_pos, de_pos, fs_pos;
    logic [11:0] rgb_pos, h_pos, v_pos;

    vga_timing_ctrl u_def (
        .clk_v(clk), .reset_v(rst), .enable_i(en_def), .data_i(d_def),
        .data_req_o(req_def), .hsync_o(hs_def), .vsync_o(vs_def), .de_o(de_def),
        .rgb_o(rgb_def), .frame_start_o(fs_def), .h_cnt_o(h_def), .v_cnt_o(v_def)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk_v(clk), .reset_v(rst), .enable_i(en_sml), .data_i(d_sml),
        .data_req_o(req_sml), .hsync_o(hs_sml), .vsync_o(vs_sml), .de_o(de_sml),
        .rgb_o(rgb_sml), .frame_start_o(fs_sml), .h_cnt_o(h_sml), .v_cnt_o(v_sml)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) u_pos (
        .clk_v(clk), .reset_v(rst), .enable_i(en_sml), .data_i(d_pos),
        .data_req_o(req_pos), .hsync_o(hs_pos), .vsync_o(vs_pos), .de_o(de_pos),
        .rgb_o(rgb_pos), .frame_start_o(fs_pos), .h_cnt_o(h_pos), .v_cnt_o(v_pos)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Small instances: echo buffer, scoreboard and raster checks
    int   sb_q[$];
    logic req_seen = 1'b0;
    int   pix = 0;
    int   cyc = 0;
    int   fs_last = -1;
    int   req_frame = 0, req_line = 0, de_line = 0;
    logic rst_p = 1'b1;
    logic hs_p = 1'b1, vs_p = 1'b1, phs_p = 1'b0, pvs_p = 1'b0;
    int   h_p = 0, v_p = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            req_seen  = 1'b0;
            d_sml     = 12'hFFF;
            fs_last   = -1;
            req_frame = 0;
            req_line  = 0;
            de_line   = 0;
        end else begin
            if (de_sml) begin
                if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("rgb_echo", int'(rgb_sml), sb_q.pop_front());
            end else begin
                chk("rgb_blank", int'(rgb_sml), 0);
            end
            chk("pos_rgb", int'(rgb_pos), de_pos ? 4095 : 0);

            if (!rst_p) begin
                if (hs_p && !hs_sml)  chk("sml_hs_fall_h", int'(h_sml), 13);
                if (!hs_p && hs_sml)  chk("sml_hs_rise_h", int'(h_sml), 1);
                if (vs_p && !vs_sml)  chk("sml_vs_fall_vh", v_sml * 100 + h_sml, 1703);
                if (!vs_p && vs_sml)  chk("sml_vs_rise_vh", v_sml * 100 + h_sml, 1803);
                if (!phs_p && hs_pos) chk("pos_hs_rise_h", int'(h_pos), 13);
                if (phs_p && !hs_pos) chk("pos_hs_fall_h", int'(h_pos), 1);
                if (!pvs_p && vs_pos) chk("pos_vs_rise_vh", v_pos * 100 + h_pos, 1703);
                if (pvs_p && !vs_pos) chk("pos_vs_fall_vh", v_pos * 100 + h_pos, 1803);
                if (h_sml == 0 && h_p != 0) chk("sml_h_wrap", h_p, 13);
                if (v_sml == 0 && v_p != 0) begin
                    chk("sml_v_wrap", v_p, 18);
                    chk("sml_v_wrap_h", int'(h_sml), 0);
                end
            end

            if (fs_sml) begin
                chk("sml_fs_pos_vh", v_sml * 100 + h_sml, 3);
                if (fs_last >= 0) begin
                    chk("sml_fs_period", cyc - fs_last, 266);
                    chk("sml_req_per_frame", req_frame, 128);
                end
                fs_last   = cyc;
                req_frame = 0;
            end
            if (req_sml) begin
                req_frame++;
                chk("sml_req_in_active", (h_sml >= 1 && h_sml <= 8 && v_sml < 16) ? 1 : 0, 1);
            end

            if (h_sml == 0) begin
                req_line = 0;
                de_line  = 0;
            end
            if (req_sml) req_line++;
            if (de_sml)  de_line++;
            if (h_sml == 9)  chk("sml_req_per_line", req_line, (v_sml < 16) ? 8 : 0);
            if (h_sml == 11) chk("sml_de_per_line", de_line, (v_sml < 16) ? 8 : 0);

            // Buffer registers its output on the request it saw last cycle
            if (req_seen) begin
                d_sml = pix[11:0];
                sb_q.push_back(pix & 4095);
                pix++;
            end else begin
                d_sml = 12'hFFF;
            end
            req_seen = req_sml;
        end
        hs_p  = hs_sml;
        vs_p  = vs_sml;
        phs_p = hs_pos;
        pvs_p = vs_pos;
        h_p   = int'(h_sml);
        v_p   = int'(v_sml);
        rst_p = rst;
    end

    // Default instance: line timing edges
    logic dhs_p = 1'b1, dde_p = 1'b0;
    int   dh_p = 0;

    always @(negedge clk) begin
        if (def_mon && !rst) begin
            if (dhs_p && !hs_def)  chk("def_hs_fall_h", int'(h_def), 659);
            if (!dhs_p && hs_def)  chk("def_hs_rise_h", int'(h_def), 755);
            if (!dde_p && de_def)  chk("def_de_rise_h", int'(h_def), 3);
            if (dde_p && !de_def)  chk("def_de_fall_h", int'(h_def), 643);
            if (h_def == 0 && dh_p != 0) chk("def_h_wrap", dh_p, 799);
        end
        dhs_p = hs_def;
        dde_p = de_def;
        dh_p  = int'(h_def);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst = 1'b1; en_def = 1'b1; en_sml = 1'b1; def_mon = 1'b0; d_def = 12'h5A5;
        repeat (3) @(negedge clk);

        chk("rst_def_req", req_def, 0);   chk("rst_def_de", de_def, 0);
        chk("rst_def_rgb", rgb_def, 0);   chk("rst_def_fs", fs_def, 0);
        chk("rst_def_hs", hs_def, 1);     chk("rst_def_vs", vs_def, 1);
        chk("rst_def_h", h_def, 0);       chk("rst_def_v", v_def, 0);
        chk("rst_sml_req", req_sml, 0);   chk("rst_sml_hs", hs_sml, 1);
        chk("rst_pos_hs", hs_pos, 0);     chk("rst_pos_vs", vs_pos, 0);

        #1 rst = 1'b0; def_mon = 1'b1;
        chk("rel_def_h0", h_def, 0);

        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            @(negedge clk);
            if (h_def == 100 && v_def == 10) found = 1;
        end
        chk("def_reach_v10_h100", found, 1);
        if (found == 1) begin
            #1 en_def = 1'b0; def_mon = 1'b0;
            @(negedge clk);
            chk("dis_req", req_def, 0); chk("dis_h", h_def, 0); chk("dis_v", v_def, 0);
            chk("dis_de_1", de_def, 1);
            @(negedge clk);
            chk("dis_de_2", de_def, 1);
            @(negedge clk);
            chk("dis_de_3", de_def, 0); chk("dis_rgb", rgb_def, 0);
            chk("dis_hs", hs_def, 1);   chk("dis_vs", vs_def, 1);
            repeat (4) @(negedge clk);
            chk("dis_hold_h", h_def, 0); chk("dis_hold_de", de_def, 0);
            chk("dis_hold_req", req_def, 0);
            #1 en_def = 1'b1;
            @(negedge clk);
            chk("reen_h", h_def, 1); chk("reen_v", v_def, 0); chk("reen_req", req_def, 1);
            repeat (10) @(negedge clk);
            #1 def_mon = 1'b1;
        end

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (de_sml) found = 1;
        end
        chk("sml_find_de", found, 1);
        #1 rst = 1'b1; def_mon = 1'b0;
        @(negedge clk);
        chk("mrst_sml_de", de_sml, 0);   chk("mrst_sml_rgb", rgb_sml, 0);
        chk("mrst_sml_req", req_sml, 0); chk("mrst_sml_fs", fs_sml, 0);
        chk("mrst_sml_hs", hs_sml, 1);   chk("mrst_sml_vs", vs_sml, 1);
        chk("mrst_sml_h", h_sml, 0);     chk("mrst_sml_v", v_sml, 0);
        chk("mrst_pos_hs", hs_pos, 0);   chk("mrst_pos_vs", vs_pos, 0);
        chk("mrst_def_de", de_def, 0);   chk("mrst_def_hs", hs_def, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("mrel_sml_h0", h_sml, 0);
        @(negedge clk);
        chk("mrel_sml_h1", h_sml, 1); chk("mrel_sml_v", v_sml, 0);
        chk("mrel_sml_req", req_sml, 1);
        repeat (5) @(negedge clk);
        #1 def_mon = 1'b1;
        repeat (700) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
